// File: rtl/up_gpio_irq_ctrl.sv
// GPIO register core: direction control, two-flop input synchronizer and
// rising/falling edge interrupt capture behind a one-cycle-latency up_* bus.
module up_gpio_irq_ctrl #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int BUS_WIDTH     = 4,
  parameter int GPIO_WIDTH    = 32,
  parameter int IRQ_ENABLE    = 0
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     up_rreq,
  output logic                     up_rack,
  input  logic [ADDRESS_WIDTH-1:0] up_raddr,
  output logic [BUS_WIDTH*8-1:0]   up_rdata,
  input  logic                     up_wreq,
  output logic                     up_wack,
  input  logic [ADDRESS_WIDTH-1:0] up_waddr,
  input  logic [BUS_WIDTH*8-1:0]   up_wdata,
  output logic                     irq,
  input  logic [GPIO_WIDTH-1:0]    gpio_io_i,
  output logic [GPIO_WIDTH-1:0]    gpio_io_o,
  output logic [GPIO_WIDTH-1:0]    gpio_io_t
);

  localparam int DW = BUS_WIDTH * 8;
  localparam int GW = GPIO_WIDTH;

  localparam logic [2:0] ADDR_DATA_IN  = 3'd0;
  localparam logic [2:0] ADDR_DATA_OUT = 3'd1;
  localparam logic [2:0] ADDR_TRI      = 3'd2;
  localparam logic [2:0] ADDR_IRQ_EN   = 3'd3;
  localparam logic [2:0] ADDR_IRQ_STAT = 3'd4;
  localparam logic [2:0] ADDR_IRQ_RISE = 3'd5;
  localparam logic [2:0] ADDR_IRQ_FALL = 3'd6;

  logic [GW-1:0] sync1_reg, sync2_reg, prev_reg;
  logic [GW-1:0] out_reg, tri_reg;
  logic [1:0]    prime_reg;
  logic          rack_reg, wack_reg;
  logic [DW-1:0] rdata_reg, rdata_next;
  logic [GW-1:0] en_reg, stat_reg, rise_arm_reg, fall_arm_reg;
  logic          irq_reg;
  logic [GW-1:0] wdata_gpio;
  logic          wr_out, wr_tri;
  logic          unused_bits;

  assign wdata_gpio = up_wdata[GW-1:0];
  assign wr_out     = up_wreq && (up_waddr[2:0] == ADDR_DATA_OUT);
  assign wr_tri     = up_wreq && (up_waddr[2:0] == ADDR_TRI);

  // Upper address bits are not decoded and the priming state is dead when
  // the interrupt logic is not built.
  assign unused_bits = ^{up_raddr, up_waddr, up_wdata, prev_reg, prime_reg};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
      prev_reg  <= '0;
      prime_reg <= 2'd0;
    end else begin
      sync1_reg <= gpio_io_i;
      sync2_reg <= sync1_reg;
      prev_reg  <= sync2_reg;
      if (prime_reg != 2'd3) prime_reg <= prime_reg + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_reg <= '0;
      tri_reg <= '1;
    end else begin
      if (wr_out) out_reg <= wdata_gpio;
      if (wr_tri) tri_reg <= wdata_gpio;
    end
  end

  generate
    if (IRQ_ENABLE != 0) begin : g_irq
      logic          primed;
      logic          wr_en, wr_stat, wr_rise, wr_fall;
      logic [GW-1:0] edge_hit, stat_next;

      assign primed  = (prime_reg == 2'd3);
      assign wr_en   = up_wreq && (up_waddr[2:0] == ADDR_IRQ_EN);
      assign wr_stat = up_wreq && (up_waddr[2:0] == ADDR_IRQ_STAT);
      assign wr_rise = up_wreq && (up_waddr[2:0] == ADDR_IRQ_RISE);
      assign wr_fall = up_wreq && (up_waddr[2:0] == ADDR_IRQ_FALL);

      // A captured edge outranks a W1C hitting the same bit in the same cycle.
      for (genvar gi = 0; gi < GW; gi++) begin : g_pin
        assign edge_hit[gi] = primed &
          ((sync2_reg[gi] & ~prev_reg[gi] & rise_arm_reg[gi]) |
           (~sync2_reg[gi] & prev_reg[gi] & fall_arm_reg[gi]));
        assign stat_next[gi] = edge_hit[gi] |
          (stat_reg[gi] & ~(wr_stat & wdata_gpio[gi]));
      end

      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          en_reg       <= '0;
          stat_reg     <= '0;
          rise_arm_reg <= '0;
          fall_arm_reg <= '0;
          irq_reg      <= 1'b0;
        end else begin
          if (wr_en)   en_reg       <= wdata_gpio;
          if (wr_rise) rise_arm_reg <= wdata_gpio;
          if (wr_fall) fall_arm_reg <= wdata_gpio;
          stat_reg <= stat_next;
          irq_reg  <= |(stat_reg & en_reg);
        end
      end
    end else begin : g_no_irq
      assign en_reg       = '0;
      assign stat_reg     = '0;
      assign rise_arm_reg = '0;
      assign fall_arm_reg = '0;
      assign irq_reg      = 1'b0;
    end
  endgenerate

  always_comb begin
    rdata_next = '0;
    case (up_raddr[2:0])
      ADDR_DATA_IN:  rdata_next[GW-1:0] = sync2_reg;
      ADDR_DATA_OUT: rdata_next[GW-1:0] = out_reg;
      ADDR_TRI:      rdata_next[GW-1:0] = tri_reg;
      ADDR_IRQ_EN:   rdata_next[GW-1:0] = en_reg;
      ADDR_IRQ_STAT: rdata_next[GW-1:0] = stat_reg;
      ADDR_IRQ_RISE: rdata_next[GW-1:0] = rise_arm_reg;
      ADDR_IRQ_FALL: rdata_next[GW-1:0] = fall_arm_reg;
      default:       rdata_next = '0;
    endcase
  end

  // Every request is acknowledged one cycle later, decoded or not.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rack_reg  <= 1'b0;
      wack_reg  <= 1'b0;
      rdata_reg <= '0;
    end else begin
      rack_reg  <= up_rreq;
      wack_reg  <= up_wreq;
      rdata_reg <= up_rreq ? rdata_next : '0;
    end
  end

  assign up_rack   = rack_reg;
  assign up_wack   = wack_reg;
  assign up_rdata  = rdata_reg;
  assign irq       = irq_reg;
  assign gpio_io_o = out_reg;
  assign gpio_io_t = tri_reg;

endmodule

// File: tb/tb_up_gpio_irq_ctrl.sv
// Directed bench: one IRQ-enabled and one IRQ-disabled instance share the bus
// and pads; each step compares against hand-computed values.
module tb_up_gpio_irq_ctrl;

  logic        clk = 1'b0;
  logic        rstn;
  logic        rreq, wreq;
  logic [31:0] raddr, waddr, wdata;
  logic [31:0] gpio_i;

  logic        rack, wack, irq;
  logic [31:0] rdata, gpio_o, gpio_t;
  logic        rack0, wack0, irq0;
  logic [31:0] rdata0, gpio_o0, gpio_t0;

  int total = 0;
  int bad   = 0;
  logic [31:0] d, d0;

  always #5 clk = ~clk;

  up_gpio_irq_ctrl #(.ADDRESS_WIDTH(32), .BUS_WIDTH(4), .GPIO_WIDTH(32), .IRQ_ENABLE(1)) dut (
    .clk(clk), .rstn(rstn),
    .up_rreq(rreq), .up_rack(rack), .up_raddr(raddr), .up_rdata(rdata),
    .up_wreq(wreq), .up_wack(wack), .up_waddr(waddr), .up_wdata(wdata),
    .irq(irq), .gpio_io_i(gpio_i), .gpio_io_o(gpio_o), .gpio_io_t(gpio_t)
  );

  up_gpio_irq_ctrl #(.ADDRESS_WIDTH(32), .BUS_WIDTH(4), .GPIO_WIDTH(32), .IRQ_ENABLE(0)) dut0 (
    .clk(clk), .rstn(rstn),
    .up_rreq(rreq), .up_rack(rack0), .up_raddr(raddr), .up_rdata(rdata0),
    .up_wreq(wreq), .up_wack(wack0), .up_waddr(waddr), .up_wdata(wdata),
    .irq(irq0), .gpio_io_i(gpio_i), .gpio_io_o(gpio_o0), .gpio_io_t(gpio_t0)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Upper address bits are randomised: only bits [2:0] may matter.
  task automatic wr(input logic [2:0] a, input logic [31:0] v);
    logic [28:0] hi;
    hi = 29'($urandom());
    @(negedge clk); wreq = 1'b1; waddr = {hi, a}; wdata = v;
    @(negedge clk); wreq = 1'b0;
    chk("wack", 32'(wack), 32'd1);
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] v, output logic [31:0] v0);
    logic [28:0] hi;
    hi = 29'($urandom());
    @(negedge clk); rreq = 1'b1; raddr = {hi, a};
    @(negedge clk); rreq = 1'b0;
    chk("rack", 32'(rack), 32'd1);
    chk("rack0", 32'(rack0), 32'd1);
    v  = rdata;
    v0 = rdata0;
  endtask

  initial begin
    rstn = 1'b0; rreq = 1'b0; wreq = 1'b0;
    raddr = '0; waddr = '0; wdata = '0; gpio_i = '1;

    // Reset state, with all pads high
    repeat (3) @(negedge clk);
    chk("rst_t", gpio_t, 32'hFFFF_FFFF);
    chk("rst_o", gpio_o, 32'h0);
    chk("rst_irq", 32'(irq), 32'd0);
    chk("rst_rack", 32'(rack), 32'd0);
    chk("rst_wack", 32'(wack), 32'd0);
    chk("rst_rdata", rdata, 32'h0);
    rstn = 1'b1;
    repeat (10) @(negedge clk);
    chk("post_t", gpio_t, 32'hFFFF_FFFF);
    chk("post_o", gpio_o, 32'h0);
    chk("post_irq", 32'(irq), 32'd0);
    rd(3'd4, d, d0); chk("post_stat", d, 32'h0);
    rd(3'd0, d, d0); chk("data_in", d, 32'hFFFF_FFFF);

    // Register access and ack timing
    wr(3'd1, 32'hA5A5_0F0F);
    chk("out_vis", gpio_o, 32'hA5A5_0F0F);
    @(negedge clk); chk("wack_width", 32'(wack), 32'd0);
    wr(3'd2, 32'h0000_FFFF);
    chk("tri_vis", gpio_t, 32'h0000_FFFF);
    rd(3'd1, d, d0); chk("rd_out", d, 32'hA5A5_0F0F);
    @(negedge clk);
    chk("rack_width", 32'(rack), 32'd0);
    chk("rdata_idle", rdata, 32'h0);
    rd(3'd2, d, d0); chk("rd_tri", d, 32'h0000_FFFF);

    // Rising edge on pin 0
    gpio_i = 32'h0;
    repeat (5) @(negedge clk);
    wr(3'd5, 32'h1);
    wr(3'd3, 32'h1);
    rd(3'd4, d, d0); chk("stat_idle", d, 32'h0);
    @(negedge clk); gpio_i[0] = 1'b1;
    @(negedge clk);
    @(negedge clk); rreq = 1'b1; raddr = 32'd4;
    @(negedge clk);
    chk("stat_pre_e2", rdata, 32'h0);
    chk("irq_e2", 32'(irq), 32'd0);
    @(negedge clk); rreq = 1'b0;
    chk("stat_e2", rdata, 32'h1);
    chk("irq_e3", 32'(irq), 32'd1);
    wr(3'd4, 32'h1);
    chk("irq_w1c_n", 32'(irq), 32'd1);
    @(negedge clk); chk("irq_w1c_n1", 32'(irq), 32'd0);

    // Masked falling edge on pin 7, then unmask
    gpio_i[7] = 1'b1;
    repeat (5) @(negedge clk);
    wr(3'd6, 32'h80);
    wr(3'd3, 32'h0);
    gpio_i[7] = 1'b0;
    repeat (5) @(negedge clk);
    rd(3'd4, d, d0); chk("stat_fall", d, 32'h80);
    chk("irq_masked", 32'(irq), 32'd0);
    wr(3'd3, 32'h80);
    chk("irq_unmask_n", 32'(irq), 32'd0);
    @(negedge clk); chk("irq_unmask_n1", 32'(irq), 32'd1);

    // Collision: new edge on pin 3 captured in the same cycle as its W1C
    wr(3'd5, 32'h08);
    wr(3'd3, 32'h88);
    gpio_i[3] = 1'b1;
    repeat (5) @(negedge clk);
    rd(3'd4, d, d0); chk("stat_b3", d, 32'h88);
    wr(3'd4, 32'h80);
    gpio_i[3] = 1'b0;
    repeat (5) @(negedge clk);
    rd(3'd4, d, d0); chk("stat_only_b3", d, 32'h08);
    @(negedge clk); gpio_i[3] = 1'b1;
    @(negedge clk);
    @(negedge clk); wreq = 1'b1; waddr = 32'd4; wdata = 32'h08;
    @(negedge clk); wreq = 1'b0;
    chk("coll_wack", 32'(wack), 32'd1);
    chk("coll_irq_a", 32'(irq), 32'd1);
    @(negedge clk); chk("coll_irq_b", 32'(irq), 32'd1);
    rd(3'd4, d, d0); chk("coll_stat", d, 32'h08);
    wr(3'd4, 32'h08);
    @(negedge clk); chk("clr_irq", 32'(irq), 32'd0);
    rd(3'd4, d, d0); chk("clr_stat", d, 32'h0);

    // Simultaneous read and write of DATA_OUT
    @(negedge clk);
    rreq = 1'b1; raddr = 32'd1; wreq = 1'b1; waddr = 32'd1; wdata = 32'h1234_5678;
    @(negedge clk); rreq = 1'b0; wreq = 1'b0;
    chk("rw_rack", 32'(rack), 32'd1);
    chk("rw_wack", 32'(wack), 32'd1);
    chk("rw_old", rdata, 32'hA5A5_0F0F);
    chk("rw_o", gpio_o, 32'h1234_5678);
    rd(3'd1, d, d0); chk("rw_new", d, 32'h1234_5678);

    // IRQ_ENABLE=0 instance against the enabled one, all pins armed
    wr(3'd3, 32'hFFFF_FFFF);
    wr(3'd5, 32'hFFFF_FFFF);
    wr(3'd6, 32'hFFFF_FFFF);
    wr(3'd4, 32'hFFFF_FFFF);
    gpio_i = ~gpio_i;
    repeat (6) @(negedge clk);
    gpio_i = ~gpio_i;
    repeat (6) @(negedge clk);
    chk("noirq_irq", 32'(irq0), 32'd0);
    chk("irq_all", 32'(irq), 32'd1);
    rd(3'd3, d, d0); chk("noirq_en", d0, 32'h0); chk("en_all", d, 32'hFFFF_FFFF);
    rd(3'd4, d, d0); chk("noirq_stat", d0, 32'h0); chk("stat_all", d, 32'hFFFF_FFFF);
    rd(3'd5, d, d0); chk("noirq_rise", d0, 32'h0);
    rd(3'd6, d, d0); chk("noirq_fall", d0, 32'h0);
    chk("noirq_o", gpio_o0, 32'h1234_5678);
    rd(3'd7, d, d0); chk("rsv", d, 32'h0); chk("rsv0", d0, 32'h0);

    // Reset in the middle of a write acknowledge
    @(negedge clk); wreq = 1'b1; waddr = 32'd1; wdata = 32'hFFFF_0000;
    @(negedge clk); wreq = 1'b0;
    chk("mid_wack", 32'(wack), 32'd1);
    chk("mid_o", gpio_o, 32'hFFFF_0000);
    #1 rstn = 1'b0;
    #1;
    chk("mid_rst_wack", 32'(wack), 32'd0);
    chk("mid_rst_o", gpio_o, 32'h0);
    chk("mid_rst_t", gpio_t, 32'hFFFF_FFFF);
    chk("mid_rst_irq", 32'(irq), 32'd0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
